// File: rtl/la_rle_encoder_if.sv
// Sample/strobe bus between the LA front end and the RLE encoder.
// Carries the samples in and the encoded words and write-qualify strobe out.
interface la_rle_encoder_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic                    CLK_EN;
  logic                    Start_Write;
  logic                    Write_Ready;
  logic                    RLE_MODE;
  logic [DATA_W-1:0]       LA_DATA_IN;
  logic                    LA_RLE_CNT_EN;
  logic [DATA_W+CNT_W-1:0] RLE_DATA_OUT;
  logic                    RLE_BUSY;

  modport master (
    output CLK_EN, Start_Write, Write_Ready, RLE_MODE, LA_DATA_IN,
    input  LA_RLE_CNT_EN, RLE_DATA_OUT, RLE_BUSY
  );

  modport slave (
    input  CLK_EN, Start_Write, Write_Ready, RLE_MODE, LA_DATA_IN,
    output LA_RLE_CNT_EN, RLE_DATA_OUT, RLE_BUSY
  );
endinterface

// File: rtl/la_rle_encoder.sv
// Run-length encoder for the LA capture path: collapses runs of equal samples
// into {value, run_length-1} words, qualified by LA_RLE_CNT_EN for the write stage.
module la_rle_encoder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic              CLK,
  input logic              nRESET,
  la_rle_encoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       cur_q, cur_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic                    en_q, en_d;
  logic                    busy_q, busy_d;
  logic [DATA_W+CNT_W-1:0] data_q, data_d;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    en_d    = en_q;
    busy_d  = busy_q;
    data_d  = data_q;
    // Disarm wins over everything and does not wait for a sample strobe.
    if (!bus.Start_Write) begin
      state_d = IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (bus.CLK_EN) begin
      unique case (state_q)
        IDLE: begin
          state_d = RUN;
          cur_d   = bus.LA_DATA_IN;
          cnt_d   = '0;
          busy_d  = 1'b1;
          mode_d  = bus.RLE_MODE;
          en_d    = 1'b0;
        end
        RUN: begin
          if (mode_q) begin
            // Flush beats a run boundary in the same sample; that sample is dropped.
            if (bus.Write_Ready) begin
              data_d  = {cur_q, cnt_q};
              en_d    = 1'b1;
              state_d = FLUSH;
            end else if (bus.LA_DATA_IN == cur_q) begin
              if (cnt_q == CNT_MAX) begin
                data_d = {cur_q, CNT_MAX};
                en_d   = 1'b1;
                cnt_d  = '0;
              end else begin
                cnt_d  = cnt_q + 1'b1;
                en_d   = 1'b0;
              end
            end else begin
              data_d = {cur_q, cnt_q};
              en_d   = 1'b1;
              cur_d  = bus.LA_DATA_IN;
              cnt_d  = '0;
            end
          end else begin
            if (bus.Write_Ready) begin
              en_d    = 1'b0;
              state_d = FLUSH;
            end else begin
              data_d = {bus.LA_DATA_IN, {CNT_W{1'b0}}};
              en_d   = 1'b1;
            end
          end
        end
        FLUSH: begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = DONE;
        end
        DONE: en_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.LA_RLE_CNT_EN = en_q;
  assign bus.RLE_DATA_OUT  = data_q;
  assign bus.RLE_BUSY      = busy_q;

endmodule

// File: tb/tb_la_rle_encoder.sv
// Directed bench for la_rle_encoder; a forked monitor checks every word the
// write stage would accept (CLK_EN & LA_RLE_CNT_EN) against a queue of expected words.
module tb_la_rle_encoder;
  logic CLK = 1'b0;
  logic nRESET;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] expq[$];

  la_rle_encoder_if #(.DATA_W(8), .CNT_W(8)) bus ();

  la_rle_encoder #(.DATA_W(8), .CNT_W(8)) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic smp(input logic en, input logic [7:0] d);
    bus.CLK_EN     = en;
    bus.LA_DATA_IN = d;
    @(posedge CLK);
    #1;
  endtask

  // Inputs are driven 1 time unit after the rising edge, so at the falling edge
  // the strobe and word seen here are exactly what the next rising edge consumes.
  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge CLK);
      if (nRESET && bus.CLK_EN && bus.LA_RLE_CNT_EN) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL word_unexpected got=%0h exp=none", bus.RLE_DATA_OUT);
        end else begin
          e = expq.pop_front();
          chk("word", {16'h0, bus.RLE_DATA_OUT}, {16'h0, e});
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    nRESET          = 1'b0;
    bus.CLK_EN      = 1'b0;
    bus.Start_Write = 1'b0;
    bus.Write_Ready = 1'b0;
    bus.RLE_MODE    = 1'b0;
    bus.LA_DATA_IN  = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_en",   {31'h0, bus.LA_RLE_CNT_EN}, 32'h0);
    chk("rst_data", {16'h0, bus.RLE_DATA_OUT},  32'h0);
    chk("rst_busy", {31'h0, bus.RLE_BUSY},      32'h0);
    nRESET = 1'b1;
    smp(1'b0, 8'h00);

    // 0x11 x4 then 0x22 -> 0x1103, strobe high for one sample
    bus.Start_Write = 1'b1;
    bus.RLE_MODE    = 1'b1;
    expq.push_back(16'h1103);
    smp(1'b1, 8'h11);
    chk("arm_busy", {31'h0, bus.RLE_BUSY}, 32'h1);
    repeat (3) smp(1'b1, 8'h11);
    chk("run_en", {31'h0, bus.LA_RLE_CNT_EN}, 32'h0);
    smp(1'b1, 8'h22);
    chk("t1_en",   {31'h0, bus.LA_RLE_CNT_EN}, 32'h1);
    chk("t1_data", {16'h0, bus.RLE_DATA_OUT},  32'h1103);
    smp(1'b1, 8'h22);
    chk("t1_en_drop", {31'h0, bus.LA_RLE_CNT_EN}, 32'h0);
    bus.Start_Write = 1'b0;
    smp(1'b0, 8'h00);
    chk("t1_disarm_busy", {31'h0, bus.RLE_BUSY}, 32'h0);

    // 600 x 0xAA: two saturated words, remainder 0x57 on flush
    bus.Start_Write = 1'b1;
    expq.push_back(16'hAAFF);
    expq.push_back(16'hAAFF);
    expq.push_back(16'hAA57);
    for (int i = 0; i < 600; i++) smp(1'b1, 8'hAA);
    bus.Write_Ready = 1'b1;
    smp(1'b1, 8'hAA);
    chk("sat_flush_en",   {31'h0, bus.LA_RLE_CNT_EN}, 32'h1);
    chk("sat_flush_data", {16'h0, bus.RLE_DATA_OUT},  32'hAA57);
    bus.Write_Ready = 1'b0;
    smp(1'b1, 8'hAA);
    chk("sat_done_en",   {31'h0, bus.LA_RLE_CNT_EN}, 32'h0);
    chk("sat_done_busy", {31'h0, bus.RLE_BUSY},      32'h0);
    bus.Start_Write = 1'b0;
    smp(1'b0, 8'h00);

    // Pass-through, sparse strobe; RLE_MODE flipped mid-run must be ignored
    bus.RLE_MODE    = 1'b0;
    bus.Start_Write = 1'b1;
    expq.push_back(16'h0100);
    expq.push_back(16'h0200);
    expq.push_back(16'h0300);
    smp(1'b1, 8'h00);
    chk("pt_arm_en", {31'h0, bus.LA_RLE_CNT_EN}, 32'h0);
    bus.RLE_MODE = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      smp(1'b1, 8'(v));
      chk("pt_data", {16'h0, bus.RLE_DATA_OUT}, {16'h0, 8'(v), 8'h00});
      smp(1'b0, 8'hFF);
      smp(1'b0, 8'hFF);
      chk("pt_hold_data", {16'h0, bus.RLE_DATA_OUT},  {16'h0, 8'(v), 8'h00});
      chk("pt_hold_en",   {31'h0, bus.LA_RLE_CNT_EN}, 32'h1);
    end
    bus.Write_Ready = 1'b1;
    smp(1'b1, 8'hEE);
    chk("pt_flush_en", {31'h0, bus.LA_RLE_CNT_EN}, 32'h0);
    bus.Write_Ready = 1'b0;
    smp(1'b1, 8'h00);
    chk("pt_done_busy", {31'h0, bus.RLE_BUSY}, 32'h0);
    bus.Start_Write = 1'b0;
    smp(1'b0, 8'h00);

    // Write_Ready coincides with 0x33->0x44: only 0x3305, 0x44 dropped
    bus.RLE_MODE    = 1'b1;
    bus.Start_Write = 1'b1;
    expq.push_back(16'h3305);
    repeat (6) smp(1'b1, 8'h33);
    bus.Write_Ready = 1'b1;
    smp(1'b1, 8'h44);
    chk("wr_data", {16'h0, bus.RLE_DATA_OUT}, 32'h3305);
    bus.Write_Ready = 1'b0;
    smp(1'b1, 8'h44);
    chk("wr_done_en",   {31'h0, bus.LA_RLE_CNT_EN}, 32'h0);
    chk("wr_done_busy", {31'h0, bus.RLE_BUSY},      32'h0);
    repeat (2) smp(1'b1, 8'h45);
    chk("wr_done_stay", {31'h0, bus.LA_RLE_CNT_EN}, 32'h0);
    bus.Start_Write = 1'b0;
    smp(1'b0, 8'h00);

    // Disarm mid-run at cnt=10 without a strobe; re-arm restarts count at 0
    bus.Start_Write = 1'b1;
    repeat (11) smp(1'b1, 8'h55);
    bus.Start_Write = 1'b0;
    smp(1'b0, 8'h55);
    chk("drop_busy", {31'h0, bus.RLE_BUSY},      32'h0);
    chk("drop_en",   {31'h0, bus.LA_RLE_CNT_EN}, 32'h0);
    bus.Start_Write = 1'b1;
    expq.push_back(16'h5502);
    repeat (3) smp(1'b1, 8'h55);
    smp(1'b1, 8'h66);
    chk("rearm_data", {16'h0, bus.RLE_DATA_OUT}, 32'h5502);
    smp(1'b1, 8'h66);
    bus.Start_Write = 1'b0;
    smp(1'b0, 8'h00);

    // Async reset with a word pending: cleared immediately, never written
    bus.Start_Write = 1'b1;
    smp(1'b1, 8'h77);
    smp(1'b1, 8'h77);
    smp(1'b1, 8'h78);
    chk("pre_rst_en", {31'h0, bus.LA_RLE_CNT_EN}, 32'h1);
    #1 nRESET = 1'b0;
    #1;
    chk("arst_en",   {31'h0, bus.LA_RLE_CNT_EN}, 32'h0);
    chk("arst_data", {16'h0, bus.RLE_DATA_OUT},  32'h0);
    chk("arst_busy", {31'h0, bus.RLE_BUSY},      32'h0);
    bus.Start_Write = 1'b0;
    bus.CLK_EN      = 1'b0;
    @(posedge CLK);
    #1 nRESET = 1'b1;
    smp(1'b1, 8'h00);
    chk("post_rst_en", {31'h0, bus.LA_RLE_CNT_EN}, 32'h0);

    chk("queue_empty", expq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
